// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: shared state encoding and opcode constants for the sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_sequencer_pkg;

  // The encoding is visible on the STATE debug port, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALTED = 3'd6,
    ST_ERROR  = 3'd7
  } seq_state_t;

  // ALU_OP value whose execute phase is multi-cycle (mod).
  localparam logic [4:0] ALU_MOD_OP = 5'b01111;

  // Width of the REQ/ACK wait counter; it covers ACK_TIMEOUT up to 255.
  localparam int unsigned TIMER_W = 8;

  // True for the states that own a memory REQ.
  function automatic logic is_req_state(input seq_state_t s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/mem_handshake_timer.sv
// mem_handshake_timer: counts cycles a memory REQ waits for ACK, flags expiry.
// Latency: expire is combinational from the count and the current REQ/ACK.
// Backpressure: none; ACK in the limit cycle suppresses expire.
// Ports: clk/rst_n; clr restarts the count; req/ack are the live handshake;
//        expire is high in the cycle the wait reaches ACK_TIMEOUT without ACK.
module mem_handshake_timer
  import cpu_sequencer_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic req,
  input  logic ack,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LIMIT_M1 = TIMER_W'(ACK_TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (req && !ack) begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  // The cycle that would bring the count to the limit is the expiry cycle,
  // so a REQ held ACK_TIMEOUT cycles without ACK errors out, while an ACK
  // arriving in that same cycle still wins.
  assign expire = req && !ack && (cnt == LIMIT_M1);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/exec/mem/wb sequencer around Control.
// Latency: 4 cycles per ALU op with 1-cycle fetch; loads/stores 5 + memory waits.
// Backpressure: IMEM/DMEM REQ held until ACK; ACK_TIMEOUT waits -> ERROR, BUS_ERR.
// Ports: CLK/RESET_N; START; IMEM_REQ/IMEM_ACK/INSTR_IN fetch; OPCODE to Control;
//        ALU_OP, REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, HALT from Control;
//        BRANCH_TAKEN, ALU_START/ALU_DONE to/from ALU; DMEM_REQ/DMEM_WE/DMEM_ACK;
//        REG_WE, PC_WE, PC_SEL pulses; HALTED, BUS_ERR, STATE status.
// Optional: define SEQ_PERF_CNT_EN to add CYCLE_CNT and RETIRED_CNT outputs.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  output logic        IMEM_REQ,
  input  logic        IMEM_ACK,
  input  logic [8:0]  INSTR_IN,
  output logic [8:0]  OPCODE,
  input  logic [4:0]  ALU_OP,
  input  logic        REG_WRITE,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic        BRANCH,
  input  logic        HALT,
  input  logic        BRANCH_TAKEN,
  output logic        ALU_START,
  input  logic        ALU_DONE,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  input  logic        DMEM_ACK,
  output logic        REG_WE,
  output logic        PC_WE,
  output logic        PC_SEL,
  output logic        HALTED,
  output logic        BUS_ERR,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0] CYCLE_CNT,
  output logic [31:0] RETIRED_CNT,
`endif
  output logic [2:0]  STATE
);

  seq_state_t state;
  seq_state_t nxt;

  logic timer_clr;
  logic timer_req;
  logic timer_ack;
  logic timer_expire;

  // FETCH and MEM never overlap, so one timer serves both handshakes.
  assign timer_req = IMEM_REQ | DMEM_REQ;
  assign timer_ack = (state == ST_FETCH) ? IMEM_ACK : DMEM_ACK;
  assign timer_clr = is_req_state(nxt) && (nxt != state);

  mem_handshake_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clr    (timer_clr),
    .req    (timer_req),
    .ack    (timer_ack),
    .expire (timer_expire)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (START) nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (IMEM_ACK)          nxt = ST_DECODE;
        else if (timer_expire) nxt = ST_ERROR;
      end
      ST_DECODE: begin
        nxt = HALT ? ST_HALTED : ST_EXEC;
      end
      ST_EXEC: begin
        // ALU_START is high only in the first EXEC cycle of a mod, which is
        // exactly the cycle whose ALU_DONE must be ignored.
        if ((ALU_OP == ALU_MOD_OP) && (ALU_START || !ALU_DONE)) nxt = ST_EXEC;
        else if (MEM_READ || MEM_WRITE)                           nxt = ST_MEM;
        else                                                       nxt = ST_WB;
      end
      ST_MEM: begin
        if (DMEM_ACK)          nxt = ST_WB;
        else if (timer_expire) nxt = ST_ERROR;
      end
      ST_WB: begin
        nxt = ST_FETCH;
      end
      ST_HALTED, ST_ERROR: begin
        if (START) nxt = ST_FETCH;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean flop
  // that is valid for the whole cycle of the state it belongs to.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      OPCODE    <= '0;
      IMEM_REQ  <= 1'b0;
      DMEM_REQ  <= 1'b0;
      DMEM_WE   <= 1'b0;
      ALU_START <= 1'b0;
      REG_WE    <= 1'b0;
      PC_WE     <= 1'b0;
      PC_SEL    <= 1'b0;
      HALTED    <= 1'b0;
      BUS_ERR   <= 1'b0;
    end else begin
      state     <= nxt;
      IMEM_REQ  <= (nxt == ST_FETCH);
      DMEM_REQ  <= (nxt == ST_MEM);
      // Read and write together behave as a write.
      DMEM_WE   <= (nxt == ST_MEM) && MEM_WRITE;
      ALU_START <= (state == ST_DECODE) && (nxt == ST_EXEC) && (ALU_OP == ALU_MOD_OP);
      // A pure store never writes the register file, whatever REG_WRITE says.
      REG_WE    <= (nxt == ST_WB) && REG_WRITE && !(MEM_WRITE && !MEM_READ);
      PC_WE     <= (nxt == ST_WB);
      PC_SEL    <= (nxt == ST_WB) && BRANCH && BRANCH_TAKEN;
      HALTED    <= (nxt == ST_HALTED);
      if (state == ST_FETCH && IMEM_ACK) OPCODE <= INSTR_IN;
      if (nxt == ST_ERROR) begin
        BUS_ERR <= 1'b1;
      end else if (START && (state == ST_HALTED || state == ST_ERROR)) begin
        BUS_ERR <= 1'b0;
      end
    end
  end

  assign STATE = state;

`ifdef SEQ_PERF_CNT_EN
  logic run_state;
  logic restart;

  assign run_state = (state != ST_IDLE) && (state != ST_HALTED) && (state != ST_ERROR);
  assign restart   = (state == ST_IDLE) && START;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CYCLE_CNT   <= '0;
      RETIRED_CNT <= '0;
    end else begin
      if (restart)        CYCLE_CNT <= '0;
      else if (run_state) CYCLE_CNT <= CYCLE_CNT + 32'd1;
      if (restart)              RETIRED_CNT <= '0;
      else if (state == ST_WB)  RETIRED_CNT <= RETIRED_CNT + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle instruction sequencer for the basic processor datapath.
- Drives fetch / decode / execute / memory / writeback ordering around the combinational Control decoder.
- Holds the 9-bit instruction register that feeds Control's OPCODE.
- Consumes Control's REG_WRITE/MEM_READ/MEM_WRITE/BRANCH/HALT and issues one-cycle enables plus REQ/ACK memory handshakes to the PC, register file and memories.

Parameters:
- ACK_TIMEOUT, 15: max cycles a memory REQ may wait for ACK before a bus error (1..255).
- ALU_MOD_OP, 5'b01111: ALU_OP encoding that needs multi-cycle execute (mod); the value lives in the package.

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  one clock; reset is asynchronous and active-low
- START  in  1  leave IDLE/HALTED/ERROR and begin fetching
- IMEM_REQ  out  1  instruction fetch request
- IMEM_ACK  in  1  instruction valid on INSTR_IN
- INSTR_IN  in  9  fetched instruction
- OPCODE  out  9  instruction register, to Control
- ALU_OP  in  5  from Control
- REG_WRITE, MEM_READ, MEM_WRITE, BRANCH, HALT  in  1 each  from Control
- BRANCH_TAKEN  in  1  branch condition from ALU
- ALU_START  out  1  one-cycle pulse for multi-cycle ALU op
- ALU_DONE  in  1  multi-cycle ALU result ready
- DMEM_REQ  out  1  data memory request
- DMEM_WE  out  1  write qualifier, valid while DMEM_REQ
- DMEM_ACK  in  1  data access complete
- REG_WE  out  1  register file write enable, one-cycle pulse
- PC_WE  out  1  PC update pulse
- PC_SEL  out  1  0 = PC+1, 1 = branch target
- HALTED  out  1  in HALTED state
- BUS_ERR  out  1  sticky memory timeout flag
- STATE  out  3  current state encoding, for debug

Behaviour:
- Reset (async, RESET_N=0):
  - State = IDLE, OPCODE = 0, timeout counter = 0, BUS_ERR = 0.
  - All other outputs are 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED, ERROR (3-bit encoding in the package).
- IDLE: START=1 -> FETCH next cycle.
- FETCH:
  - IMEM_REQ=1 held until IMEM_ACK.
  - On ACK: OPCODE <= INSTR_IN, then -> DECODE.
  - ACK in the first FETCH cycle is legal, giving a 1-cycle fetch.
- DECODE: one cycle, so Control outputs settle.
  - HALT=1 -> HALTED, with no PC_WE.
  - Otherwise -> EXEC.
- EXEC:
  - If ALU_OP==ALU_MOD_OP: ALU_START pulses in the first EXEC cycle; stay in EXEC until ALU_DONE. ALU_DONE in the same cycle as ALU_START is ignored.
  - Else: single cycle.
  - Exit: MEM_READ|MEM_WRITE -> MEM; else -> WB.
- MEM:
  - DMEM_REQ=1 and DMEM_WE=MEM_WRITE, held until DMEM_ACK, then -> WB.
  - MEM_READ and MEM_WRITE both set: treated as write.
- WB: one cycle.
  - REG_WE=REG_WRITE, except forced 0 for pure stores.
  - PC_WE=1; PC_SEL=BRANCH&BRANCH_TAKEN.
  - -> FETCH.
- Per-instruction latency:
  - ALU op with 1-cycle fetch: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles plus memory wait cycles.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each cycle REQ is high without ACK.
  - Reaching ACK_TIMEOUT -> ERROR: BUS_ERR=1, REQ dropped.
  - ACK arriving in the same cycle the counter reaches the limit wins (no error).
- HALTED/ERROR:
  - HALTED=1 while in HALTED.
  - START -> FETCH, clears BUS_ERR, and does not re-execute the halt.
  - PC is not advanced past hlt by the sequencer; software or the PC owner resolves this.
- START outside IDLE/HALTED/ERROR: ignored.
- Reset mid-operation: immediate return to IDLE; outstanding REQ dropped asynchronously.
- REQ outputs are registered, with no combinational ACK->REQ path.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- When defined, adds outputs CYCLE_CNT[31:0] and RETIRED_CNT[31:0]:
  - CYCLE_CNT increments every cycle outside IDLE/HALTED/ERROR.
  - RETIRED_CNT increments on each WB cycle.
  - Both wrap at 2^32, reset to 0, and clear on START from IDLE.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package definitions: the seq_state_t enum, ALU_MOD_OP, and the STATE encodings.
- One sub-module, mem_handshake_timer:
  - Implements the REQ/ACK timeout counter.
  - Instantiated once and shared by FETCH and MEM, since they are mutually exclusive.

Test Plan:
- Reset, then START with ACK immediate and INSTR=add (000000000) -> IMEM_REQ 1 cycle, REG_WE and PC_WE pulse 3 cycles later, PC_SEL=0, STATE returns to FETCH.
- lw (001000010) with DMEM_ACK delayed 3 cycles -> DMEM_REQ high 4 cycles, DMEM_WE=0, REG_WE at WB. sw (001011010) -> DMEM_WE=1, REG_WE=0.
- mod with ALU_DONE after 5 cycles -> ALU_START single pulse, EXEC held 6 cycles, then WB.
- bne with BRANCH_TAKEN=1 -> PC_SEL=1 on the PC_WE cycle. Same instruction with BRANCH_TAKEN=0 -> PC_SEL=0.
- hlt (001100000) -> HALTED=1 after DECODE, no PC_WE. START -> FETCH resumes.
- IMEM_ACK never asserted, ACK_TIMEOUT=15 -> ERROR after 15 REQ cycles, BUS_ERR=1. ACK exactly on the 15th cycle -> no error. RESET_N low mid-MEM -> IDLE, DMEM_REQ=0 immediately.
